// File: rtl/param_updown_counter.sv
// Parametrised modulo-MODULUS up/down counter with load, wrap/saturate modes,
// terminal-count flag, wrap pulse and a wrap-event counter.
module param_updown_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              wrap,
  output logic              sat,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);
  // One extra bit so MODULUS == 2**WIDTH is representable for the load clamp.
  localparam logic [WIDTH:0]   ModExt   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0]  out_d;
  logic              wrap_d;
  logic              sat_d;
  logic [WRAP_W-1:0] wrap_cnt_d;

  logic at_max;
  logic at_min;

  assign at_max = (out == MaxVal);
  assign at_min = (out == '0);
  assign tc     = up_dn ? at_max : at_min;

  always_comb begin
    out_d      = out;
    wrap_d     = 1'b0;
    sat_d      = 1'b0;
    wrap_cnt_d = wrap_cnt;
    if (load) begin
      out_d = ({1'b0, load_val} < ModExt) ? load_val : MaxVal;
    end else if (en) begin
      if (up_dn) begin
        if (!at_max) begin
          out_d = out + 1'b1;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          out_d      = '0;
          wrap_d     = 1'b1;
          wrap_cnt_d = wrap_cnt + 1'b1;
        end
      end else begin
        if (!at_min) begin
          out_d = out - 1'b1;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          out_d      = MaxVal;
          wrap_d     = 1'b1;
          wrap_cnt_d = wrap_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= ResetVal;
      wrap     <= 1'b0;
      sat      <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      out      <= out_d;
      wrap     <= wrap_d;
      sat      <= sat_d;
      wrap_cnt <= wrap_cnt_d;
    end
  end

endmodule
